// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and constants for the TDM demultiplexer.
//   state_e       : frame-lock FSM states (hunt, check, locked)
//   MAX_CH        : widest supported frame (data channels)
//   SlotW         : slot counter width (covers MAX_CH data slots + parity slot)
//   Pin* params   : bit positions within io_in / io_out
package tdm_demux_pkg;

   typedef enum logic [1:0] {
      StHunt,
      StCheck,
      StLocked
   } state_e;

   localparam int unsigned MAX_CH = 4;
   localparam int unsigned SlotW  = 3;

   // io_in bit positions
   localparam int unsigned PinClk  = 0;
   localparam int unsigned PinRstN = 1;
   localparam int unsigned PinSd   = 2;
   localparam int unsigned PinSync = 3;
   localparam int unsigned PinEn   = 4;

   // io_out bit positions (data occupies [MAX_CH-1:0])
   localparam int unsigned PinData0   = 0;
   localparam int unsigned PinStb     = 4;
   localparam int unsigned PinLocked  = 5;
   localparam int unsigned PinSyncErr = 6;
   localparam int unsigned PinParErr  = 7;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: frame slot counter, 0..Len-1 with wrap.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset (slot -> 0)
//   en_i         : slot advance enable; nothing changes when low
//   clr_i        : force slot to 0 (highest priority)
//   load_i       : force slot to 1 (sync seen at slot 0 of a new frame)
//   inc_i        : advance one slot, wrapping from Len-1 to 0
//   slot_o       : current slot
//   last_slot_o  : slot_o == Len-1
module tdm_slot_ctr
   import tdm_demux_pkg::*;
#(
   parameter int unsigned Len = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             inc_i,
   output logic [SlotW-1:0] slot_o,
   output logic             last_slot_o
);

   logic [SlotW-1:0] slot_q, slot_d;

   assign last_slot_o = (slot_q == SlotW'(Len - 1));
   assign slot_o      = slot_q;

   always_comb begin
      slot_d = slot_q;
      if (en_i) begin
         if (clr_i) begin
            slot_d = '0;
         end else if (load_i) begin
            slot_d = SlotW'(1);
         end else if (inc_i) begin
            slot_d = last_slot_o ? '0 : slot_q + SlotW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: four-channel time-division demultiplexer (TinyTapeout slot).
// Recovers NUM_CH single-bit channels from a serial line framed by a slot-0 sync
// pulse, publishing them atomically once per good frame.
//   io_in[0]    clock          io_in[1] async active-low reset
//   io_in[2]    sd (data)      io_in[3] sync (slot 0)   io_in[4] en (slot advance)
//   io_in[7:5]  unused
//   io_out[3:0] published channels (bits >= NUM_CH tied 0)
//   io_out[4]   frame_stb      io_out[5] locked
//   io_out[6]   sync_err       io_out[7] par_err
// Optional feature: define TDM_DEMUX_PARITY_EN to add a trailing even-parity slot.
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int unsigned FrameLen = NUM_CH + 1;
`else
   localparam int unsigned FrameLen = NUM_CH;
`endif

   logic clk, rst_n, sd, sync, en;
   assign clk   = io_in[PinClk];
   assign rst_n = io_in[PinRstN];
   assign sd    = io_in[PinSd];
   assign sync  = io_in[PinSync];
   assign en    = io_in[PinEn];

   logic unused_io_in;
   assign unused_io_in = ^io_in[7:5];

   state_e              state_q;
   logic [MAX_CH-1:0]   shadow_q;
   logic [MAX_CH-1:0]   data_q;
   logic                stb_q, sync_err_q;
   logic [SlotW-1:0]    slot;
   logic                last_slot;

   logic                active, hunt_hit, at_zero, sync_bad, sync_miss, step;
   logic                do_pub, par_ok;
   logic [MAX_CH-1:0]   pub_data;

   always_comb begin
      active    = en && (state_q != StHunt);
      hunt_hit  = en && (state_q == StHunt) && sync;
      at_zero   = (slot == '0);
      sync_bad  = active && sync && !at_zero;
      sync_miss = active && !sync && at_zero;
      step      = active && !sync_bad && !sync_miss;
      do_pub    = step && (state_q == StLocked) && last_slot;
      // Frame as it will be published: the channel in the current slot comes
      // straight from sd, the rest from the shadow.
      pub_data  = '0;
      for (int i = 0; i < int'(MAX_CH); i++) begin
         if (i < int'(NUM_CH)) begin
            pub_data[i] = (slot == SlotW'(i)) ? sd : shadow_q[i];
         end
      end
`ifdef TDM_DEMUX_PARITY_EN
      par_ok = ((^pub_data) == sd);
`else
      par_ok = 1'b1;
`endif
   end

   tdm_slot_ctr #(
      .Len (FrameLen)
   ) u_slot_ctr (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .clr_i       (sync_miss),
      .load_i      (hunt_hit | sync_bad),
      .inc_i       (step),
      .slot_o      (slot),
      .last_slot_o (last_slot)
   );

`ifdef TDM_DEMUX_PARITY_EN
   logic par_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= do_pub && !par_ok;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StHunt;
         shadow_q   <= '0;
         data_q     <= '0;
         stb_q      <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         // Pulses last one cycle regardless of en.
         stb_q      <= 1'b0;
         sync_err_q <= 1'b0;
         if (hunt_hit) begin
            shadow_q[0] <= sd;
            state_q     <= StCheck;
         end
         if (sync_bad) begin
            // Treat the unexpected sync as the start of a new frame.
            sync_err_q  <= 1'b1;
            shadow_q[0] <= sd;
            state_q     <= StCheck;
         end
         if (sync_miss) begin
            sync_err_q <= 1'b1;
            state_q    <= StHunt;
         end
         if (step) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
               if (slot == SlotW'(i)) begin
                  shadow_q[i] <= sd;
               end
            end
            if (state_q == StCheck && at_zero) begin
               state_q <= StLocked;
            end
            if (do_pub && par_ok) begin
               data_q <= pub_data;
               stb_q  <= 1'b1;
            end
         end
      end
   end

   assign io_out[PinData0 +: MAX_CH] = data_q;
   assign io_out[PinStb]             = stb_q;
   assign io_out[PinLocked]          = (state_q == StLocked);
   assign io_out[PinSyncErr]         = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign io_out[PinParErr]          = par_err_q;
`else
   assign io_out[PinParErr]          = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux (NUM_CH = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tdm_demux;

`ifdef TDM_DEMUX_PARITY_EN
   localparam int L = 5;
`else
   localparam int L = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sd = 1'b0;
   logic       sync = 1'b0;
   logic       en = 1'b0;
   logic [7:0] io_in;
   logic [7:0] io_out;
   int         n_cmp = 0;
   int         n_err = 0;

   assign io_in = {3'b000, en, sync, sd, rst_n, clk};

   tdm_demux #(
      .NUM_CH (4)
   ) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: io_out=%h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, return at the next falling edge.
   task automatic drive(input logic s, input logic y, input logic e);
      sd   = s;
      sync = y;
      en   = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Full frame, ch k = d[k], sync on slot 0; optional parity slot (flip -> bad).
   task automatic send_frame(input logic [3:0] d, input logic par_flip);
      drive(d[0], 1'b1, 1'b1);
      for (int i = 1; i < 4; i++) drive(d[i], 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
      drive((^d) ^ par_flip, 1'b0, 1'b1);
`else
      if (par_flip) drive(1'b0, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", io_out, 8'h00);
      rst_n = 1'b1;

      // Lock and publish
      send_frame(4'b1011, 1'b0);
      chk("check_frame_not_published", io_out, 8'h00);
      drive(1'b1, 1'b1, 1'b1);
      chk("lock_rise", io_out, 8'h20);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
      drive(1'b1, 1'b0, 1'b1);
`endif
      chk("first_publish", io_out, 8'h3B);
      drive(1'b0, 1'b0, 1'b0);
      chk("stb_one_cycle", io_out, 8'h2B);

      // False sync at slot 2
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
      chk("false_sync", io_out, 8'h4B);
      for (int i = 1; i < L; i++) drive(1'b1, 1'b0, 1'b1);
      chk("resync_check_no_pub", io_out, 8'h0B);
      drive(1'b1, 1'b1, 1'b1);
      chk("relock", io_out, 8'h2B);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
      drive(1'b0, 1'b0, 1'b1);
`endif
      chk("relock_publish", io_out, 8'h35);

      // Missing sync at slot 0
      drive(1'b0, 1'b0, 1'b1);
      chk("missing_sync", io_out, 8'h45);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      chk("hunt_idle", io_out, 8'h05);
      send_frame(4'b1011, 1'b0);
      chk("hunt_check_no_pub", io_out, 8'h05);
      send_frame(4'b1011, 1'b0);
      chk("hunt_relock_publish", io_out, 8'h3B);

      // Stall between slots 1 and 2; a sync during the stall is ignored
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("stall_no_err", io_out, 8'h2B);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
      drive(1'b0, 1'b0, 1'b1);
`endif
      chk("stall_publish", io_out, 8'h36);
      drive(1'b0, 1'b0, 1'b0);
      chk("stall_single_stb", io_out, 8'h26);

`ifdef TDM_DEMUX_PARITY_EN
      // Parity: bad then good
      send_frame(4'b1011, 1'b1);
      chk("par_bad", io_out, 8'hA6);
      drive(1'b0, 1'b0, 1'b0);
      chk("par_hold", io_out, 8'h26);
      send_frame(4'b1011, 1'b0);
      chk("par_good", io_out, 8'h3B);
`endif

      // Reset mid-frame at slot 2
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      sd    = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("reset_async", io_out, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(4'b1011, 1'b0);
      chk("reset_check_no_pub", io_out, 8'h00);
      send_frame(4'b1011, 1'b0);
      chk("reset_publish", io_out, 8'h3B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
